// File: rtl/pf_xcvr_ref_clk_pkg.sv
// Shared types and helpers for the transceiver reference-clock monitor.
package pf_xcvr_ref_clk_pkg;

  typedef enum logic [1:0] {
    S_NONE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FORCED = 2'd2
  } sel_state_t;

  // Width of a channel index: at least one bit even for a single channel.
  function automatic int sel_w_f(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Index of the lowest set bit; returns 0 when no bit is set.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/pf_xcvr_ref_clk_monitor_freq_meter.sv
// Per-channel edge counter, window judgement and health flag.
module pf_xcvr_ref_clk_monitor_freq_meter #(
  parameter int CNT_W    = 16,
  parameter int EXP_CNT  = 1024,
  parameter int TOL      = 8,
  parameter int GOOD_WIN = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_tgl,
  input  logic             i_en,
  input  logic             i_meas_done,
  output logic [CNT_W-1:0] o_last_cnt,
  output logic             o_ch_ok
);

  localparam int               STK_W   = $clog2(GOOD_WIN + 1);
  localparam logic [CNT_W:0]   EXP_V   = (CNT_W + 1)'(EXP_CNT);
  localparam logic [CNT_W:0]   TOL_V   = (CNT_W + 1)'(TOL);
  localparam logic [STK_W-1:0] GOOD_V  = STK_W'(GOOD_WIN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                    r_tgl;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        r_last;
  logic [STK_W-1:0]        r_streak;
  logic                    r_ok;
  logic                    w_edge;
  logic                    w_sat;
  logic                    w_good;
  logic signed [CNT_W:0]   w_diff;
  logic [CNT_W:0]          w_abs;
  logic [STK_W-1:0]        w_streak_inc;

  // Edge detect and window judgement; a saturated count is never good.
  always_comb begin
    w_edge = i_tgl ^ r_tgl;
    w_sat  = (r_cnt == CNT_MAX);
    w_diff = $signed({1'b0, r_cnt}) - $signed(EXP_V);
    if (w_diff[CNT_W]) begin
      w_abs = $unsigned(-w_diff);
    end else begin
      w_abs = $unsigned(w_diff);
    end
    w_good = !w_sat && (w_abs <= TOL_V);
    if (r_streak == GOOD_V) begin
      w_streak_inc = GOOD_V;
    end else begin
      w_streak_inc = r_streak + 1'b1;
    end
  end

  // Registered copy of the toggle for both-edge detection.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tgl <= 1'b0;
    end else begin
      r_tgl <= i_tgl;
    end
  end

  // Edge counter, good-window streak and health; a disabled channel is held at zero.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_en) begin
      r_cnt    <= '0;
      r_streak <= '0;
      r_ok     <= 1'b0;
    end else if (i_meas_done) begin
      r_cnt <= CNT_W'(w_edge);
      if (w_good) begin
        r_streak <= w_streak_inc;
        r_ok     <= (w_streak_inc == GOOD_V);
      end else begin
        r_streak <= '0;
        r_ok     <= 1'b0;
      end
    end else if (w_edge && !w_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Capture the closing window's count for readout.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last <= '0;
    end else if (i_meas_done) begin
      r_last <= r_cnt;
    end
  end

  assign o_last_cnt = r_last;
  assign o_ch_ok    = r_ok;

endmodule

// File: rtl/pf_xcvr_ref_clk_monitor.sv
// Reference-clock health monitor with non-revertive priority failover select.
module pf_xcvr_ref_clk_monitor
  import pf_xcvr_ref_clk_pkg::*;
#(
  parameter int  NUM_CH   = 2,
  parameter int  WINDOW   = 4096,
  parameter int  CNT_W    = 16,
  parameter int  EXP_CNT  = 1024,
  parameter int  TOL      = 8,
  parameter int  GOOD_WIN = 2,
  localparam int SEL_W    = sel_w_f(NUM_CH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NUM_CH-1:0] i_refclk_tgl,
  input  logic [NUM_CH-1:0] i_ch_en,
  input  logic              i_force_sel_en,
  input  logic [SEL_W-1:0]  i_force_sel,
  output logic [SEL_W-1:0]  o_sel,
  output logic              o_sel_valid,
  output logic [NUM_CH-1:0] o_ch_ok,
  output logic              o_switch_pulse,
  output logic              o_meas_done,
  input  logic [SEL_W-1:0]  i_cnt_rd_idx,
  output logic [CNT_W-1:0]  o_cnt_rd_data
);

  localparam int               WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [SEL_W:0]   NUM_CH_V = (SEL_W + 1)'(NUM_CH);

  logic [WIN_W-1:0]  r_win;
  logic              r_meas_done;
  logic              r_decide;
  logic [NUM_CH-1:0] w_ch_ok;
  logic [CNT_W-1:0]  w_last [NUM_CH];
  logic [CNT_W-1:0]  w_rd;
  logic [CNT_W-1:0]  r_rd;
  logic [7:0]        w_ok8;
  logic              w_any;
  logic [SEL_W-1:0]  w_low;
  logic              w_sel_ok;
  logic              w_force_in;
  logic              w_force_ok;
  sel_state_t        r_state;
  sel_state_t        w_next_state;
  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  w_next_sel;
  logic              r_sel_valid;
  logic              w_next_valid;
  logic              r_switch;
  logic              w_next_switch;

  // Free-running window counter; MEAS_DONE follows the terminal cycle, decisions one cycle later.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_win       <= '0;
      r_meas_done <= 1'b0;
      r_decide    <= 1'b0;
    end else begin
      r_win       <= (r_win == WIN_LAST) ? '0 : r_win + 1'b1;
      r_meas_done <= (r_win == WIN_LAST);
      r_decide    <= r_meas_done;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    pf_xcvr_ref_clk_monitor_freq_meter #(
      .CNT_W    (CNT_W),
      .EXP_CNT  (EXP_CNT),
      .TOL      (TOL),
      .GOOD_WIN (GOOD_WIN)
    ) u_meter (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_tgl       (i_refclk_tgl[gi]),
      .i_en        (i_ch_en[gi]),
      .i_meas_done (r_meas_done),
      .o_last_cnt  (w_last[gi]),
      .o_ch_ok     (w_ch_ok[gi])
    );
  end

  // Health lookups for the selector and the count readout mux.
  always_comb begin
    w_ok8              = 8'd0;
    w_ok8[NUM_CH-1:0]  = w_ch_ok;
    w_any              = |w_ch_ok;
    w_low              = SEL_W'(lowest_set(w_ok8));
    w_sel_ok           = w_ok8[3'(r_sel)];
    w_force_in         = ({1'b0, i_force_sel} < NUM_CH_V);
    w_force_ok         = w_ok8[3'(i_force_sel)];
    w_rd               = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_rd = (i_cnt_rd_idx == SEL_W'(i)) ? w_last[i] : w_rd;
    end
  end

  // Registered count readout, one cycle after the index.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd <= '0;
    end else begin
      r_rd <= w_rd;
    end
  end

  // Selection next-state: force has priority; automatic moves only in decision cycles.
  always_comb begin
    w_next_state = r_state;
    w_next_sel   = r_sel;
    w_next_valid = r_sel_valid;
    w_next_switch = 1'b0;
    if (i_force_sel_en) begin
      w_next_state = S_FORCED;
      if (w_force_in) begin
        w_next_sel   = i_force_sel;
        w_next_valid = w_force_ok;
      end else begin
        w_next_valid = 1'b0;
      end
    end else begin
      case (r_state)
        S_FORCED: begin
          if (w_sel_ok) begin
            w_next_state = S_ACTIVE;
            w_next_valid = 1'b1;
          end else begin
            w_next_state = S_NONE;
            w_next_valid = 1'b0;
          end
        end
        S_NONE: begin
          w_next_valid = 1'b0;
          if (r_decide && w_any) begin
            w_next_state  = S_ACTIVE;
            w_next_sel    = w_low;
            w_next_valid  = 1'b1;
            // Acquiring a channel from no selection is announced even if the index is unchanged.
            w_next_switch = 1'b1;
          end else begin
            w_next_state = S_NONE;
          end
        end
        S_ACTIVE: begin
          if (r_decide && !w_sel_ok) begin
            if (w_any) begin
              w_next_sel   = w_low;
              w_next_valid = 1'b1;
            end else begin
              w_next_state = S_NONE;
              w_next_valid = 1'b0;
            end
          end else begin
            w_next_state = S_ACTIVE;
          end
        end
        default: begin
          w_next_state = S_NONE;
          w_next_valid = 1'b0;
        end
      endcase
    end
    w_next_switch = w_next_switch | (w_next_sel != r_sel);
  end

  // Selection state and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_NONE;
      r_sel       <= '0;
      r_sel_valid <= 1'b0;
      r_switch    <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_sel       <= w_next_sel;
      r_sel_valid <= w_next_valid;
      r_switch    <= w_next_switch;
    end
  end

  assign o_sel          = r_sel;
  assign o_sel_valid    = r_sel_valid;
  assign o_ch_ok        = w_ch_ok;
  assign o_switch_pulse = r_switch;
  assign o_meas_done    = r_meas_done;
  assign o_cnt_rd_data  = r_rd;

endmodule

// File: tb/tb_pf_xcvr_ref_clk_monitor.sv
// Directed bench: main DUT with three channels (channel 2 unused) so an
// out-of-range force index is expressible, plus a small saturating instance.
module tb_pf_xcvr_ref_clk_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  tgl, en;
  logic        fen;
  logic [1:0]  fsel, rd_idx;
  logic [1:0]  sel;
  logic        valid, sw, md;
  logic [2:0]  ok;
  logic [15:0] rd;

  logic        s_tgl;
  logic        s_sel, s_valid, s_sw, s_md;
  logic [1:0]  s_ok;
  logic [9:0]  s_rd;

  int ph;
  int tgt [3];
  bit term;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pf_xcvr_ref_clk_monitor #(.NUM_CH(3)) dut (
    .i_clk(clk), .i_reset(rst), .i_refclk_tgl(tgl), .i_ch_en(en),
    .i_force_sel_en(fen), .i_force_sel(fsel), .o_sel(sel), .o_sel_valid(valid),
    .o_ch_ok(ok), .o_switch_pulse(sw), .o_meas_done(md),
    .i_cnt_rd_idx(rd_idx), .o_cnt_rd_data(rd)
  );

  pf_xcvr_ref_clk_monitor #(.NUM_CH(2), .WINDOW(1100), .CNT_W(10),
                            .EXP_CNT(1020), .TOL(8), .GOOD_WIN(2)) dut_sat (
    .i_clk(clk), .i_reset(rst), .i_refclk_tgl({s_tgl, s_tgl}), .i_ch_en(2'b11),
    .i_force_sel_en(1'b0), .i_force_sel(1'b0), .o_sel(s_sel), .o_sel_valid(s_valid),
    .o_ch_ok(s_ok), .o_switch_pulse(s_sw), .o_meas_done(s_md),
    .i_cnt_rd_idx(1'b0), .o_cnt_rd_data(s_rd)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One clock: toggles scheduled at even phases 0,2,..,2(N-1) give exactly N edges per window.
  task automatic step();
    for (int c = 0; c < 3; c++) begin
      if ((ph % 2 == 0) && (ph < 2 * tgt[c])) tgl[c] = ~tgl[c];
    end
    if (term && ph == 4095) tgl[0] = ~tgl[0];
    s_tgl = ~s_tgl;
    @(posedge clk);
    #1;
    ph = (ph + 1) % 4096;
  endtask

  task automatic adv_to(input int t);
    do step(); while (ph != t);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_sel"}, 32'(sel), 32'd0);
    check_eq({tag, "_valid"}, 32'(valid), 32'd0);
    check_eq({tag, "_ok"}, 32'(ok), 32'd0);
    check_eq({tag, "_sw"}, 32'(sw), 32'd0);
    check_eq({tag, "_md"}, 32'(md), 32'd0);
    check_eq({tag, "_rd"}, 32'(rd), 32'd0);
  endtask

  initial begin
    rst = 1'b1; tgl = 3'b000; en = 3'b011; fen = 1'b0; fsel = 2'd0; rd_idx = 2'd0;
    s_tgl = 1'b0; ph = 0; term = 1'b0;
    tgt[0] = 1024; tgt[1] = 1024; tgt[2] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    rst = 1'b0; ph = 0;

    // T1: both channels nominal
    adv_to(0);    check_eq("t1_md", 32'(md), 32'd1);
    adv_to(1);    check_eq("t1_ok_w1", 32'(ok), 32'd0);
    adv_to(2);    check_eq("t1_rd", 32'(rd), 32'd1024);
    adv_to(0);
    adv_to(1);    check_eq("t1_ok_w2", 32'(ok), 32'd3);
                  check_eq("t1_valid_pre", 32'(valid), 32'd0);
    adv_to(2);    check_eq("t1_sel", 32'(sel), 32'd0);
                  check_eq("t1_valid", 32'(valid), 32'd1);
                  check_eq("t1_sw", 32'(sw), 32'd1);
                  check_eq("sat_ok", 32'(s_ok), 32'd0);
                  check_eq("sat_rd", 32'(s_rd), 32'd1023);
    adv_to(3);    check_eq("t1_sw_end", 32'(sw), 32'd0);

    // T2: channel 0 slow, failover, then recovery without revert
    tgt[0] = 819;
    adv_to(1);    check_eq("t2_ok", 32'(ok), 32'd2);
    adv_to(2);    check_eq("t2_sel", 32'(sel), 32'd1);
                  check_eq("t2_sw", 32'(sw), 32'd1);
                  check_eq("t2_valid", 32'(valid), 32'd1);
                  check_eq("t2_rd", 32'(rd), 32'd819);
    adv_to(3);    check_eq("t2_sw_end", 32'(sw), 32'd0);
    tgt[0] = 1024;
    adv_to(1);    check_eq("t2_ok_w1", 32'(ok), 32'd2);
    adv_to(1);    check_eq("t2_ok_w2", 32'(ok), 32'd3);
    adv_to(2);    check_eq("t2_norevert_sel", 32'(sel), 32'd1);
                  check_eq("t2_norevert_sw", 32'(sw), 32'd0);

    // T3: tolerance boundaries
    tgt[0] = 1016; tgt[1] = 1033; rd_idx = 2'd1;
    adv_to(1);    check_eq("t3_ok_a", 32'(ok), 32'd1);
    adv_to(2);    check_eq("t3_sel_a", 32'(sel), 32'd0);
                  check_eq("t3_sw_a", 32'(sw), 32'd1);
                  check_eq("t3_rd_a", 32'(rd), 32'd1033);
    tgt[0] = 1015; tgt[1] = 1032; rd_idx = 2'd0;
    adv_to(1);    check_eq("t3_ok_b", 32'(ok), 32'd0);
    adv_to(2);    check_eq("t3_sel_b", 32'(sel), 32'd0);
                  check_eq("t3_valid_b", 32'(valid), 32'd0);
                  check_eq("t3_sw_b", 32'(sw), 32'd0);
                  check_eq("t3_rd_b", 32'(rd), 32'd1015);

    // T4: force override and channel disable
    adv_to(3);
    tgt[0] = 1024; tgt[1] = 1024; fen = 1'b1; fsel = 2'd0;
    adv_to(4);    check_eq("t4_f0_sel", 32'(sel), 32'd0);
                  check_eq("t4_f0_valid", 32'(valid), 32'd0);
    fsel = 2'd1;
    adv_to(5);    check_eq("t4_f1_sel", 32'(sel), 32'd1);
                  check_eq("t4_f1_sw", 32'(sw), 32'd1);
    fsel = 2'd3;
    adv_to(6);    check_eq("t4_f3_sel", 32'(sel), 32'd1);
                  check_eq("t4_f3_valid", 32'(valid), 32'd0);
                  check_eq("t4_f3_sw", 32'(sw), 32'd0);
    adv_to(1);    check_eq("t4_ok", 32'(ok), 32'd2);
    fsel = 2'd1;
    adv_to(2);    check_eq("t4_f1ok_valid", 32'(valid), 32'd1);
                  check_eq("t4_f1ok_sw", 32'(sw), 32'd0);
    fen = 1'b0;
    adv_to(3);    check_eq("t4_rel_valid", 32'(valid), 32'd1);
                  check_eq("t4_rel_sel", 32'(sel), 32'd1);
    en = 3'b001;
    adv_to(4);    check_eq("t4_dis_ok", 32'(ok), 32'd0);
    adv_to(1);    check_eq("t4_ok_w", 32'(ok), 32'd1);
    adv_to(2);    check_eq("t4_fo_sel", 32'(sel), 32'd0);
                  check_eq("t4_fo_sw", 32'(sw), 32'd1);
                  check_eq("t4_fo_valid", 32'(valid), 32'd1);

    // T5: reset mid-window
    adv_to(2000);
    rst = 1'b1; tgl = 3'b000; en = 3'b011;
    @(posedge clk);
    #1;
    check_reset("t5");
    rst = 1'b0; ph = 0;
    adv_to(4095); check_eq("t5_md_early", 32'(md), 32'd0);
    adv_to(0);    check_eq("t5_md", 32'(md), 32'd1);
    adv_to(1);    check_eq("t5_ok_w1", 32'(ok), 32'd0);
                  check_eq("t5_valid_w1", 32'(valid), 32'd0);
    adv_to(1);    check_eq("t5_ok_w2", 32'(ok), 32'd3);
                  check_eq("t5_valid_pre", 32'(valid), 32'd0);
    adv_to(2);    check_eq("t5_sel", 32'(sel), 32'd0);
                  check_eq("t5_valid", 32'(valid), 32'd1);
                  check_eq("t5_sw", 32'(sw), 32'd1);

    // T6: edge in the terminal cycle, readout latency
    tgt[0] = 1020; term = 1'b1;
    adv_to(1);    term = 1'b0;
    adv_to(2);    check_eq("t6_rd_term", 32'(rd), 32'd1021);
    rd_idx = 2'd1;
    adv_to(3);    check_eq("t6_rd_idx1", 32'(rd), 32'd1024);
    rd_idx = 2'd0;
    adv_to(2);    check_eq("t6_rd_next", 32'(rd), 32'd1020);
                  check_eq("t6_ok", 32'(ok), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
